// File: rtl/inst_pipe.sv
// inst_pipe: PC register and IF/ID..MEM/WB instruction/PC pipeline with stall and retire counters
module inst_pipe #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        npc_sel,
    input  logic [31:0] npc,
    input  logic [31:0] im_instr,
    output logic [31:0] pc,
    output logic [31:0] if_id_I,
    output logic [31:0] id_ex_I,
    output logic [31:0] ex_mem_I,
    output logic [31:0] mem_wb_I,
    output logic [31:0] if_id_pc,
    output logic [31:0] id_ex_pc,
    output logic [31:0] ex_mem_pc,
    output logic [31:0] mem_wb_pc,
    output logic [31:0] stall_cnt,
    output logic [31:0] retire_cnt
);
    logic [31:0] r_pc, r_if_id_I, r_id_ex_I, r_ex_mem_I, r_mem_wb_I;
    logic [31:0] r_if_id_pc, r_id_ex_pc, r_ex_mem_pc, r_mem_wb_pc;
    logic [31:0] r_stall_cnt, r_retire_cnt;
    logic [31:0] w_next_pc;

    // redirect target is word-aligned; no flush, so the delay slot enters IF/ID normally
    always_comb w_next_pc = npc_sel ? {npc[31:2], 2'b00} : r_pc + 32'd4;

    // fetch side: PC and IF/ID freeze on stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_if_id_I  <= NOP;
            r_if_id_pc <= '0;
        end else if (!stall) begin
            r_pc       <= w_next_pc;
            r_if_id_I  <= im_instr;
            r_if_id_pc <= r_pc;
        end
    end

    // ID/EX takes a bubble on stall; later stages always advance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id_ex_I   <= NOP;
            r_id_ex_pc  <= '0;
            r_ex_mem_I  <= NOP;
            r_ex_mem_pc <= '0;
            r_mem_wb_I  <= NOP;
            r_mem_wb_pc <= '0;
        end else begin
            r_id_ex_I   <= stall ? NOP : r_if_id_I;
            r_id_ex_pc  <= stall ? '0 : r_if_id_pc;
            r_ex_mem_I  <= r_id_ex_I;
            r_ex_mem_pc <= r_id_ex_pc;
            r_mem_wb_I  <= r_ex_mem_I;
            r_mem_wb_pc <= r_ex_mem_pc;
        end
    end

    // performance counters: stalled cycles and non-bubble words leaving WB
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_stall_cnt  <= r_stall_cnt + {31'd0, stall};
            r_retire_cnt <= r_retire_cnt + {31'd0, r_mem_wb_I != NOP};
        end
    end

    assign pc         = r_pc;
    assign if_id_I    = r_if_id_I;
    assign id_ex_I    = r_id_ex_I;
    assign ex_mem_I   = r_ex_mem_I;
    assign mem_wb_I   = r_mem_wb_I;
    assign if_id_pc   = r_if_id_pc;
    assign id_ex_pc   = r_id_ex_pc;
    assign ex_mem_pc  = r_ex_mem_pc;
    assign mem_wb_pc  = r_mem_wb_pc;
    assign stall_cnt  = r_stall_cnt;
    assign retire_cnt = r_retire_cnt;
endmodule

// File: tb/tb_inst_pipe.sv
// tb_inst_pipe: directed-vector self-checking bench for inst_pipe
module tb_inst_pipe;
    logic        clk = 1'b0;
    logic        reset, stall, npc_sel;
    logic [31:0] npc, im_instr;
    logic [31:0] pc, if_id_I, id_ex_I, ex_mem_I, mem_wb_I;
    logic [31:0] if_id_pc, id_ex_pc, ex_mem_pc, mem_wb_pc, stall_cnt, retire_cnt;
    int          errors = 0;
    int          checks = 0;

    inst_pipe dut (
        .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel), .npc(npc),
        .im_instr(im_instr), .pc(pc), .if_id_I(if_id_I), .id_ex_I(id_ex_I),
        .ex_mem_I(ex_mem_I), .mem_wb_I(mem_wb_I), .if_id_pc(if_id_pc),
        .id_ex_pc(id_ex_pc), .ex_mem_pc(ex_mem_pc), .mem_wb_pc(mem_wb_pc),
        .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; npc_sel = 1'b0; npc = '0; im_instr = 32'h2408_0001;
        step();
        check("rst_pc", pc, 32'h3000);
        check("rst_if_id_I", if_id_I, 32'h0);
        check("rst_mem_wb_I", mem_wb_I, 32'h0);
        check("rst_if_id_pc", if_id_pc, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);
        check("rst_retire_cnt", retire_cnt, 32'h0);
        // free run
        reset = 1'b0;
        step(); check("run_pc1", pc, 32'h3004);
        step(); check("run_pc2", pc, 32'h3008);
        step(); check("run_pc3", pc, 32'h300C);
        step(); check("run_pc4", pc, 32'h3010);
        check("run_if_id_pc", if_id_pc, 32'h300C);
        check("run_mem_wb_I", mem_wb_I, 32'h2408_0001);
        check("run_mem_wb_pc", mem_wb_pc, 32'h3000);
        check("run_retire4", retire_cnt, 32'h0);
        step(); check("run_retire5", retire_cnt, 32'h1);
        check("run_pc5", pc, 32'h3014);
        // stall scenario
        reset = 1'b1; step();
        reset = 1'b0; im_instr = 32'h8C08_0000;
        step(); step();
        check("st_pre_pc", pc, 32'h3008);
        check("st_pre_if_id_I", if_id_I, 32'h8C08_0000);
        stall = 1'b1; im_instr = 32'h1111_1111;
        step();
        check("st1_pc", pc, 32'h3008);
        check("st1_if_id_I", if_id_I, 32'h8C08_0000);
        check("st1_if_id_pc", if_id_pc, 32'h3004);
        check("st1_id_ex_I", id_ex_I, 32'h0);
        check("st1_id_ex_pc", id_ex_pc, 32'h0);
        check("st1_ex_mem_I", ex_mem_I, 32'h8C08_0000);
        check("st1_ex_mem_pc", ex_mem_pc, 32'h3000);
        step();
        check("st2_pc", pc, 32'h3008);
        check("st2_id_ex_I", id_ex_I, 32'h0);
        check("st2_ex_mem_I", ex_mem_I, 32'h0);
        check("st2_mem_wb_I", mem_wb_I, 32'h8C08_0000);
        check("st2_mem_wb_pc", mem_wb_pc, 32'h3000);
        check("st2_stall_cnt", stall_cnt, 32'h2);
        stall = 1'b0;
        step();
        check("st3_pc", pc, 32'h300C);
        check("st3_id_ex_I", id_ex_I, 32'h8C08_0000);
        check("st3_id_ex_pc", id_ex_pc, 32'h3004);
        check("st3_if_id_I", if_id_I, 32'h1111_1111);
        check("st3_retire", retire_cnt, 32'h1);
        check("st3_stall_cnt", stall_cnt, 32'h2);
        // redirect with delay slot
        reset = 1'b1; step();
        reset = 1'b0; im_instr = 32'h0000_0011;
        step(); step(); step(); step();
        check("br_pre_pc", pc, 32'h3010);
        npc_sel = 1'b1; npc = 32'h0000_3103; im_instr = 32'h0000_0022;
        step();
        check("br_pc", pc, 32'h3100);
        check("br_if_id_pc", if_id_pc, 32'h3010);
        check("br_if_id_I", if_id_I, 32'h0000_0022);
        npc_sel = 1'b0;
        step();
        check("br_next_pc", pc, 32'h3104);
        check("br_next_if_id_pc", if_id_pc, 32'h3100);
        // stall beats redirect
        stall = 1'b1; npc_sel = 1'b1; npc = 32'h0000_3200;
        step();
        check("sb_hold_pc", pc, 32'h3104);
        stall = 1'b0;
        step();
        check("sb_pc", pc, 32'h3200);
        check("sb_stall_cnt", stall_cnt, 32'h1);
        // pc wrap
        npc = 32'hFFFF_FFFC;
        step();
        check("wr_pre_pc", pc, 32'hFFFF_FFFC);
        npc_sel = 1'b0;
        step();
        check("wr_pc", pc, 32'h0);
        check("wr_if_id_pc", if_id_pc, 32'hFFFF_FFFC);
        // reset during stall with full pipe
        im_instr = 32'h0000_0033;
        step(); step(); step(); step();
        check("rs_pre_mem_wb_I", mem_wb_I, 32'h0000_0033);
        stall = 1'b1; reset = 1'b1;
        step();
        check("rs_pc", pc, 32'h3000);
        check("rs_if_id_I", if_id_I, 32'h0);
        check("rs_id_ex_I", id_ex_I, 32'h0);
        check("rs_ex_mem_I", ex_mem_I, 32'h0);
        check("rs_mem_wb_I", mem_wb_I, 32'h0);
        check("rs_mem_wb_pc", mem_wb_pc, 32'h0);
        check("rs_stall_cnt", stall_cnt, 32'h0);
        check("rs_retire_cnt", retire_cnt, 32'h0);
        stall = 1'b0; reset = 1'b0; im_instr = 32'h0000_0044;
        step();
        check("rs_post_pc", pc, 32'h3004);
        check("rs_post_if_id_I", if_id_I, 32'h0000_0044);
        check("rs_post_if_id_pc", if_id_pc, 32'h3000);
        check("rs_post_retire", retire_cnt, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
